// File: rtl/i2s_apb_master.sv
`default_nettype none
// ============================================================================
// i2s_apb_master : APB master sequencing control, TxFIFO and RxFIFO accesses
//                  of one I2S_top register slave.
// Revision 1.0
// ============================================================================
module i2s_apb_master #(
    parameter logic [31:0] ADR_OFFSET = 32'h0,
    parameter logic [31:0] CTRL_ADR   = 32'h0,
    parameter logic [31:0] TX_ADR     = 32'h4,
    parameter logic [31:0] RX_ADR     = 32'h8
) (
    input  logic        pclk_i,
    input  logic        preset_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    input  logic [31:0] prdata_i,
    input  logic        tx_full_i,
    input  logic        rx_empty_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [31:0] cfg_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    input  logic [31:0] tx_data_i,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic [31:0] rx_data_o,
    output logic        busy_o,
    output logic [15:0] tx_cnt_o,
    output logic [15:0] rx_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t      state_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] paddr_q;
    logic [31:0] pwdata_q;
    logic        rx_valid_q;
    logic [31:0] rx_data_q;
    logic [15:0] tx_cnt_q;
    logic [15:0] rx_cnt_q;
    logic        xfer_tx_q;
    logic        prefer_rx_q;

    logic        w_idle;
    logic        w_tx_req;
    logic        w_rx_req;
    logic        w_grant_cfg;
    logic        w_grant_tx;
    logic        w_grant_rx;
    logic [31:0] paddr_d;
    logic [31:0] pwdata_d;

    // The RX request is held off while the output buffer still holds a sample.
    assign w_idle      = (state_q == S_IDLE);
    assign w_tx_req    = tx_valid_i && !tx_full_i;
    assign w_rx_req    = !rx_empty_i && !rx_valid_q;
    assign w_grant_cfg = w_idle && cfg_valid_i;
    assign w_grant_tx  = w_idle && !cfg_valid_i && w_tx_req && (!w_rx_req || !prefer_rx_q);
    assign w_grant_rx  = w_idle && !cfg_valid_i && w_rx_req && (!w_tx_req || prefer_rx_q);

    assign paddr_d  = w_grant_cfg ? (ADR_OFFSET + CTRL_ADR) :
                      w_grant_tx  ? (ADR_OFFSET + TX_ADR)   :
                                    (ADR_OFFSET + RX_ADR);
    assign pwdata_d = w_grant_cfg ? cfg_data_i : tx_data_i;

    always_ff @(posedge pclk_i or negedge preset_i) begin
        if (!preset_i) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 32'h0;
            pwdata_q    <= 32'h0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 32'h0;
            tx_cnt_q    <= 16'h0;
            rx_cnt_q    <= 16'h0;
            xfer_tx_q   <= 1'b0;
            prefer_rx_q <= 1'b1;
        end else begin
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_grant_cfg || w_grant_tx || w_grant_rx) begin
                        state_q   <= S_SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= !w_grant_rx;
                        paddr_q   <= paddr_d;
                        xfer_tx_q <= w_grant_tx;
                        if (!w_grant_rx) begin
                            pwdata_q <= pwdata_d;
                        end
                        if (!w_grant_cfg) begin
                            prefer_rx_q <= !prefer_rx_q;
                        end
                    end
                end
                S_SETUP: begin
                    state_q   <= S_ACCESS;
                    penable_q <= 1'b1;
                end
                S_ACCESS: begin
                    state_q   <= S_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    if (!pwrite_q) begin
                        rx_data_q  <= prdata_i;
                        rx_valid_q <= 1'b1;
                        rx_cnt_q   <= rx_cnt_q + 16'd1;
                    end else if (xfer_tx_q) begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign cfg_ready_o = w_grant_cfg;
    assign tx_ready_o  = w_grant_tx;
    assign rx_valid_o  = rx_valid_q;
    assign rx_data_o   = rx_data_q;
    assign busy_o      = !w_idle;
    assign tx_cnt_o    = tx_cnt_q;
    assign rx_cnt_o    = rx_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_apb_master.sv
`default_nettype none
// ============================================================================
// tb_i2s_apb_master : scoreboard bench for i2s_apb_master with an APB slave model.
// Revision 1.0
// ============================================================================
module tb_i2s_apb_master;

    localparam logic [31:0] ADR_OFFSET = 32'h10;
    localparam logic [31:0] A_CTRL     = ADR_OFFSET + 32'h0;
    localparam logic [31:0] A_TX       = ADR_OFFSET + 32'h4;
    localparam logic [31:0] A_RX       = ADR_OFFSET + 32'h8;

    logic        pclk = 1'b0;
    logic        preset_i = 1'b0;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o;
    logic [31:0] prdata_i = 32'h0;
    logic        tx_full_i = 1'b0;
    logic        rx_empty_i = 1'b1;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] cfg_data_i = 32'h0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [31:0] tx_data_i = 32'h0;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic [31:0] rx_data_o;
    logic        busy_o;
    logic [15:0] tx_cnt_o, rx_cnt_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] rx_exp_q[$];
    logic [31:0] tx_exp_q[$];
    logic [31:0] cfg_exp_q[$];
    logic [31:0] rd_val = 32'hDEAD_BEEF;
    logic [31:0] tx_next = 32'h0;
    logic [31:0] exp_v;
    bit          tx_hs = 1'b0;
    int          cfg_hs_cnt = 0;

    i2s_apb_master #(
        .ADR_OFFSET(ADR_OFFSET),
        .CTRL_ADR  (32'h0),
        .TX_ADR    (32'h4),
        .RX_ADR    (32'h8)
    ) dut (
        .pclk_i     (pclk),
        .preset_i   (preset_i),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .paddr_o    (paddr_o),
        .pwdata_o   (pwdata_o),
        .prdata_i   (prdata_i),
        .tx_full_i  (tx_full_i),
        .rx_empty_i (rx_empty_i),
        .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o),
        .cfg_data_i (cfg_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_data_i  (tx_data_i),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .rx_data_o  (rx_data_o),
        .busy_o     (busy_o),
        .tx_cnt_o   (tx_cnt_o),
        .rx_cnt_o   (rx_cnt_o)
    );

    always #5 pclk = ~pclk;

    // Called at a falling edge; records handshakes, advances one cycle, plays the slave.
    task automatic step();
        #1;
        tx_hs = 1'b0;
        if (tx_valid_i && tx_ready_o) begin
            tx_exp_q.push_back(tx_data_i);
            tx_hs = 1'b1;
        end
        if (cfg_valid_i && cfg_ready_o) begin
            cfg_exp_q.push_back(cfg_data_i);
            cfg_hs_cnt++;
        end
        @(posedge pclk);
        #1;
        if (psel_o && penable_o && !pwrite_o) begin
            prdata_i = rd_val;
            rx_exp_q.push_back(rd_val);
            rd_val = rd_val + 32'h0101_0101;
        end
        @(negedge pclk);
    endtask

    task automatic test_reset();
        int bad = 0;
        preset_i = 1'b0;
        repeat (3) step();
        checks++;
        if ({psel_o, penable_o, pwrite_o, cfg_ready_o, tx_ready_o, rx_valid_o, busy_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 0000000",
                     {psel_o, penable_o, pwrite_o, cfg_ready_o, tx_ready_o, rx_valid_o, busy_o});
        end
        checks++;
        if ({paddr_o, pwdata_o, rx_data_o} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rx_data=%h expected all 0", paddr_o, pwdata_o, rx_data_o);
        end
        checks++;
        if ({tx_cnt_o, rx_cnt_o} !== 32'h0) begin
            errors++;
            $display("FAIL reset_cnt: tx_cnt=%0d rx_cnt=%0d expected 0", tx_cnt_o, rx_cnt_o);
        end
        preset_i = 1'b1;
        repeat (20) begin
            step();
            if (psel_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d busy cycles expected 0", bad);
        end
    endtask

    task automatic test_cfg_write();
        cfg_data_i  = 32'h0000_00A5;
        cfg_valid_i = 1'b1;
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready: got %b expected 1", cfg_ready_o);
        end
        step();
        cfg_valid_i = 1'b0;
        checks++;
        if ({psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== {3'b101, A_CTRL, 32'h0000_00A5}) begin
            errors++;
            $display("FAIL cfg_setup: psel/pen/pwr=%b%b%b paddr=%h pwdata=%h expected 101 %h 000000a5",
                     psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, A_CTRL);
        end
        step();
        checks++;
        if ({psel_o, penable_o} !== 2'b11 || cfg_exp_q.size() == 0) begin
            errors++;
            $display("FAIL cfg_access: psel/pen=%b%b queued=%0d expected 11 with 1 queued",
                     psel_o, penable_o, cfg_exp_q.size());
        end else begin
            exp_v = cfg_exp_q.pop_front();
            checks++;
            if (pwdata_o !== exp_v) begin
                errors++;
                $display("FAIL cfg_wdata: got %h expected %h", pwdata_o, exp_v);
            end
        end
        step();
        step();
        checks++;
        if (psel_o !== 1'b0 || tx_cnt_o !== 16'h0 || cfg_hs_cnt !== 1) begin
            errors++;
            $display("FAIL cfg_done: psel=%b tx_cnt=%0d cfg_handshakes=%0d expected 0 0 1",
                     psel_o, tx_cnt_o, cfg_hs_cnt);
        end
    endtask

    task automatic test_priority();
        cfg_data_i  = 32'h0000_005A;
        cfg_valid_i = 1'b1;
        tx_data_i   = 32'h5555_0000;
        tx_valid_i  = 1'b1;
        rx_empty_i  = 1'b0;
        rx_ready_i  = 1'b1;
        #1;
        checks++;
        if ({cfg_ready_o, tx_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL prio_ready: cfg_ready/tx_ready=%b%b expected 10", cfg_ready_o, tx_ready_o);
        end
        step();
        cfg_valid_i = 1'b0;
        tx_valid_i  = 1'b0;
        rx_empty_i  = 1'b1;
        checks++;
        if (paddr_o !== A_CTRL || pwrite_o !== 1'b1) begin
            errors++;
            $display("FAIL prio_addr: paddr=%h pwrite=%b expected %h 1", paddr_o, pwrite_o, A_CTRL);
        end
        step();
        checks++;
        if (cfg_exp_q.size() == 0) begin
            errors++;
            $display("FAIL prio_queue: got empty expected 1 entry");
        end else begin
            exp_v = cfg_exp_q.pop_front();
            if (pwdata_o !== exp_v) begin
                errors++;
                $display("FAIL prio_wdata: got %h expected %h", pwdata_o, exp_v);
            end
        end
        repeat (2) step();
    endtask

    task automatic test_alternation();
        bit exp_read = 1'b1;
        int nxfer = 0;
        tx_next    = 32'hA000_0001;
        tx_data_i  = tx_next;
        tx_valid_i = 1'b1;
        tx_full_i  = 1'b0;
        rx_empty_i = 1'b0;
        rx_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (rx_valid_o && rx_ready_i) begin
                checks++;
                if (rx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL alt_rx_queue: rx_data=%h with nothing expected", rx_data_o);
                end else begin
                    exp_v = rx_exp_q.pop_front();
                    if (rx_data_o !== exp_v) begin
                        errors++;
                        $display("FAIL alt_rx_data: got %h expected %h", rx_data_o, exp_v);
                    end
                end
            end
            step();
            if (tx_hs) begin
                tx_next   = tx_next + 32'h1;
                tx_data_i = tx_next;
            end
            if (psel_o && !penable_o) begin
                checks++;
                if ({pwrite_o, paddr_o} !== {~exp_read, (exp_read ? A_RX : A_TX)}) begin
                    errors++;
                    $display("FAIL alt_order: pwrite=%b paddr=%h expected %b %h",
                             pwrite_o, paddr_o, ~exp_read, (exp_read ? A_RX : A_TX));
                end
                exp_read = ~exp_read;
            end
            if (psel_o && penable_o) begin
                nxfer++;
                if (pwrite_o) begin
                    checks++;
                    if (tx_exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL alt_tx_queue: pwdata=%h with nothing expected", pwdata_o);
                    end else begin
                        exp_v = tx_exp_q.pop_front();
                        if (pwdata_o !== exp_v) begin
                            errors++;
                            $display("FAIL alt_tx_data: got %h expected %h", pwdata_o, exp_v);
                        end
                    end
                end
                if (nxfer == 6) begin
                    tx_valid_i = 1'b0;
                    rx_empty_i = 1'b1;
                end
            end
        end
        checks++;
        if (nxfer !== 6 || tx_cnt_o !== 16'd3 || rx_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL alt_counts: xfers=%0d tx_cnt=%0d rx_cnt=%0d expected 6 3 3", nxfer, tx_cnt_o, rx_cnt_o);
        end
        checks++;
        if (rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL alt_drain: rx left=%0d tx left=%0d expected 0 0", rx_exp_q.size(), tx_exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int  reads = 0;
        int  writes = 0;
        bit  resumed = 1'b0;
        rx_ready_i = 1'b0;
        tx_data_i  = tx_next;
        tx_valid_i = 1'b1;
        rx_empty_i = 1'b0;
        for (int c = 0; c < 45; c++) begin
            step();
            if (tx_hs) begin
                tx_next   = tx_next + 32'h1;
                tx_data_i = tx_next;
            end
            if (psel_o && !penable_o && !pwrite_o) reads++;
            if (psel_o && penable_o && pwrite_o) begin
                writes++;
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp_tx_queue: pwdata=%h with nothing expected", pwdata_o);
                end else begin
                    exp_v = tx_exp_q.pop_front();
                    if (pwdata_o !== exp_v) begin
                        errors++;
                        $display("FAIL bp_tx_data: got %h expected %h", pwdata_o, exp_v);
                    end
                end
            end
            if (rx_valid_o) begin
                checks++;
                if (rx_exp_q.size() == 0 || rx_data_o !== rx_exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_rx_hold: rx_data=%h queued=%0d", rx_data_o, rx_exp_q.size());
                end
            end
        end
        checks++;
        if (reads !== 1 || writes < 10 || rx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: reads=%0d writes=%0d rx_valid=%b expected 1 >=10 1", reads, writes, rx_valid_o);
        end
        rx_ready_i = 1'b1;
        checks++;
        if (rx_exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_rx_queue: got empty expected 1 entry");
        end else begin
            exp_v = rx_exp_q.pop_front();
            if (rx_data_o !== exp_v) begin
                errors++;
                $display("FAIL bp_rx_data: got %h expected %h", rx_data_o, exp_v);
            end
        end
        step();
        if (tx_hs) begin
            tx_next   = tx_next + 32'h1;
            tx_data_i = tx_next;
        end
        checks++;
        if (rx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_clear: rx_valid=%b expected 0", rx_valid_o);
        end
        for (int c = 0; c < 20; c++) begin
            if (psel_o && penable_o && pwrite_o) begin
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp2_tx_queue: pwdata=%h with nothing expected", pwdata_o);
                end else begin
                    exp_v = tx_exp_q.pop_front();
                    if (pwdata_o !== exp_v) begin
                        errors++;
                        $display("FAIL bp2_tx_data: got %h expected %h", pwdata_o, exp_v);
                    end
                end
            end
            if (rx_valid_o && rx_ready_i) begin
                checks++;
                if (rx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bp2_rx_queue: rx_data=%h with nothing expected", rx_data_o);
                end else begin
                    exp_v = rx_exp_q.pop_front();
                    if (rx_data_o !== exp_v) begin
                        errors++;
                        $display("FAIL bp2_rx_data: got %h expected %h", rx_data_o, exp_v);
                    end
                end
            end
            step();
            if (tx_hs) begin
                tx_next   = tx_next + 32'h1;
                tx_data_i = tx_next;
            end
            if (psel_o && !penable_o && !pwrite_o && !resumed) begin
                resumed    = 1'b1;
                tx_valid_i = 1'b0;
                rx_empty_i = 1'b1;
            end
        end
        checks++;
        if (!resumed || rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_resume: resumed=%b rx left=%0d tx left=%0d expected 1 0 0",
                     resumed, rx_exp_q.size(), tx_exp_q.size());
        end
    endtask

    task automatic test_full_flag();
        int bad = 0;
        bit seen = 1'b0;
        tx_full_i  = 1'b1;
        tx_valid_i = 1'b1;
        tx_data_i  = 32'h1234_5678;
        rx_empty_i = 1'b1;
        rx_ready_i = 1'b1;
        repeat (50) begin
            step();
            if (psel_o !== 1'b0 || tx_ready_o !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL full_block: %0d cycles with activity expected 0", bad);
        end
        tx_full_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (tx_hs) tx_valid_i = 1'b0;
            if (psel_o && penable_o && pwrite_o && paddr_o == A_TX && !seen) begin
                seen = 1'b1;
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL full_queue: pwdata=%h with nothing expected", pwdata_o);
                end else begin
                    exp_v = tx_exp_q.pop_front();
                    if (pwdata_o !== exp_v || exp_v !== 32'h1234_5678) begin
                        errors++;
                        $display("FAIL full_wdata: got %h expected 12345678", pwdata_o);
                    end
                end
            end
        end
        tx_valid_i = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL full_release: write seen=%b expected 1 within 4 cycles", seen);
        end
        repeat (2) step();
    endtask

    task automatic test_reset_mid_read();
        bit found = 1'b0;
        rx_ready_i = 1'b0;
        tx_valid_i = 1'b0;
        rx_empty_i = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            step();
            if (psel_o && penable_o && !pwrite_o) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_find: read access phase seen=%b expected 1", found);
        end
        preset_i = 1'b0;
        #1;
        checks++;
        if ({psel_o, penable_o, rx_valid_o, busy_o} !== 4'b0) begin
            errors++;
            $display("FAIL mid_async: psel/pen/rx_valid/busy=%b expected 0000",
                     {psel_o, penable_o, rx_valid_o, busy_o});
        end
        rx_exp_q.delete();
        rx_empty_i = 1'b1;
        step();
        preset_i = 1'b1;
        repeat (5) step();
        checks++;
        if (rx_valid_o !== 1'b0 || rx_cnt_o !== 16'h0 || tx_cnt_o !== 16'h0) begin
            errors++;
            $display("FAIL mid_after: rx_valid=%b rx_cnt=%0d tx_cnt=%0d expected 0 0 0",
                     rx_valid_o, rx_cnt_o, tx_cnt_o);
        end
    endtask

    initial begin
        @(negedge pclk);
        test_reset();
        test_cfg_write();
        test_priority();
        test_alternation();
        test_backpressure();
        test_full_flag();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
